// File: rtl/issue_pkg.sv
// Shared types and helpers for the out-of-order issue queue.
package issue_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_TAG_W = 6;
  localparam int IQ_OP_W  = 5;

  typedef struct packed {
    logic                valid;
    logic [IQ_OP_W-1:0]  opcode;
    logic [IQ_TAG_W-1:0] src1_tag;
    logic                src1_rdy;
    logic [IQ_TAG_W-1:0] src2_tag;
    logic                src2_rdy;
    logic [IQ_TAG_W-1:0] dest_tag;
  } iq_entry_t;

  // Index of the lowest clear bit among the first n bits; returns n when all are set.
  function automatic int lowest_free(input logic [31:0] busy, input int n);
    int idx;
    idx = n;
    for (int i = 31; i >= 0; i--) begin
      if ((i < n) && !busy[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/issue_age_select.sv
// Oldest-ready-first arbiter driven by an age matrix (older[j][i]: j is older than i).
module issue_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] candidate,
  input  logic [DEPTH-1:0] older [DEPTH],
  output logic [DEPTH-1:0] grant,
  output logic             any_grant
);

  logic [DEPTH-1:0] blocked_s;

  // A candidate wins when no other candidate is older than it.
  always_comb begin
    blocked_s = '0;
    grant     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        blocked_s[i] = blocked_s[i] | (candidate[j] & older[j][i]);
      end
      grant[i] = candidate[i] & ~blocked_s[i];
    end
    any_grant = |grant;
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: CDB wakeup, dispatch bypass, age-ordered select and a
// registered valid/ready issue port.
module issue_queue
  import issue_pkg::*;
#(
  parameter  int DEPTH = IQ_DEPTH,
  parameter  int TAG_W = IQ_TAG_W,
  parameter  int OP_W  = IQ_OP_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_opcode,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             disp_src1_ready,
  input  logic             disp_src2_ready,
  input  logic [TAG_W-1:0] disp_dest_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [OP_W-1:0]  issue_opcode,
  output logic [TAG_W-1:0] issue_src1_tag,
  output logic [TAG_W-1:0] issue_src2_tag,
  output logic [TAG_W-1:0] issue_dest_tag,
  output logic [CNT_W-1:0] occupancy
);

  iq_entry_t        entries_r [DEPTH];
  logic [DEPTH-1:0] older_r   [DEPTH];
  logic [DEPTH-1:0] valid_s, wake1_s, wake2_s, cand_s, grant_s;
  logic             any_grant_s, load_en_s, issue_take_s, disp_acc_s;
  int               free_idx_s;
  iq_entry_t        new_s;
  logic [OP_W-1:0]  sel_op_s;
  logic [TAG_W-1:0] sel_src1_s, sel_src2_s, sel_dest_s;

  assign disp_ready   = reset && !flush && (occupancy < CNT_W'(DEPTH));
  assign disp_acc_s   = disp_valid && disp_ready;
  assign load_en_s    = !issue_valid || issue_ready;
  assign issue_take_s = load_en_s && any_grant_s;
  assign free_idx_s   = lowest_free(32'(valid_s), DEPTH);

  // Per-entry CDB tag match and effective readiness for select.
  always_comb begin
    valid_s = '0;
    wake1_s = '0;
    wake2_s = '0;
    cand_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i] = entries_r[i].valid;
      wake1_s[i] = cdb_valid && (cdb_tag == entries_r[i].src1_tag);
      wake2_s[i] = cdb_valid && (cdb_tag == entries_r[i].src2_tag);
      cand_s[i]  = entries_r[i].valid
                 && (entries_r[i].src1_rdy || wake1_s[i])
                 && (entries_r[i].src2_rdy || wake2_s[i]);
    end
  end

  // Incoming micro-op, with sources bypassed from a same-cycle broadcast.
  always_comb begin
    new_s          = '0;
    new_s.valid    = 1'b1;
    new_s.opcode   = disp_opcode;
    new_s.src1_tag = disp_src1_tag;
    new_s.src2_tag = disp_src2_tag;
    new_s.dest_tag = disp_dest_tag;
    new_s.src1_rdy = disp_src1_ready || (cdb_valid && (cdb_tag == disp_src1_tag));
    new_s.src2_rdy = disp_src2_ready || (cdb_valid && (cdb_tag == disp_src2_tag));
  end

  issue_age_select #(.DEPTH(DEPTH)) u_select (
    .candidate (cand_s),
    .older     (older_r),
    .grant     (grant_s),
    .any_grant (any_grant_s)
  );

  // AND-OR mux of the granted entry; the grant is one-hot.
  always_comb begin
    sel_op_s   = '0;
    sel_src1_s = '0;
    sel_src2_s = '0;
    sel_dest_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_op_s   = sel_op_s   | ({OP_W{grant_s[i]}}  & entries_r[i].opcode);
      sel_src1_s = sel_src1_s | ({TAG_W{grant_s[i]}} & entries_r[i].src1_tag);
      sel_src2_s = sel_src2_s | ({TAG_W{grant_s[i]}} & entries_r[i].src2_tag);
      sel_dest_s = sel_dest_s | ({TAG_W{grant_s[i]}} & entries_r[i].dest_tag);
    end
  end

  // Entry array, age matrix, output register and occupancy; later writes win.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i].valid <= 1'b0;
        older_r[i]         <= '0;
      end
      occupancy      <= '0;
      issue_valid    <= 1'b0;
      issue_opcode   <= '0;
      issue_src1_tag <= '0;
      issue_src2_tag <= '0;
      issue_dest_tag <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake1_s[i]) entries_r[i].src1_rdy <= 1'b1;
        if (wake2_s[i]) entries_r[i].src2_rdy <= 1'b1;
      end
      if (disp_acc_s) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (k == free_idx_s) begin
            entries_r[k] <= new_s;
            older_r[k]   <= '0;
            for (int j = 0; j < DEPTH; j++) begin
              older_r[j][k] <= valid_s[j];
            end
          end
        end
      end
      // The issued slot is always distinct from the dispatch slot, which was free.
      if (issue_take_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (grant_s[i]) begin
            entries_r[i].valid <= 1'b0;
            older_r[i]         <= '0;
            for (int j = 0; j < DEPTH; j++) begin
              older_r[j][i] <= 1'b0;
            end
          end
        end
      end
      if (load_en_s) begin
        if (any_grant_s) begin
          issue_valid    <= 1'b1;
          issue_opcode   <= sel_op_s;
          issue_src1_tag <= sel_src1_s;
          issue_src2_tag <= sel_src2_s;
          issue_dest_tag <= sel_dest_s;
        end else begin
          issue_valid    <= 1'b0;
          issue_opcode   <= '0;
          issue_src1_tag <= '0;
          issue_src2_tag <= '0;
          issue_dest_tag <= '0;
        end
      end
      occupancy <= occupancy + CNT_W'(disp_acc_s) - CNT_W'(issue_take_s);
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic against an age-ordered queue model.
module tb_issue_queue;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, flush, disp_valid, disp_ready;
  logic [4:0] disp_opcode;
  logic [5:0] disp_src1_tag, disp_src2_tag, disp_dest_tag;
  logic       disp_src1_ready, disp_src2_ready;
  logic       cdb_valid;
  logic [5:0] cdb_tag;
  logic       issue_valid, issue_ready;
  logic [4:0] issue_opcode;
  logic [5:0] issue_src1_tag, issue_src2_tag, issue_dest_tag;
  logic [3:0] occupancy;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_ready(disp_src1_ready), .disp_src2_ready(disp_src2_ready),
    .disp_dest_tag(disp_dest_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opcode(issue_opcode),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .issue_dest_tag(issue_dest_tag), .occupancy(occupancy)
  );

  // Model: waiting micro-ops kept oldest-first in a queue, plus the output slot.
  typedef struct {
    logic [4:0] op;
    logic [5:0] s1, s2, d;
    bit         r1, r2;
  } mop_t;

  mop_t mq[$];
  mop_t m_out;
  bit   m_iv, m_dr;
  logic dr_seen;
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic bit rdy_eff(bit r, logic [5:0] t);
    return r || (cdb_valid && (cdb_tag == t));
  endfunction

  task automatic tick();
    mop_t n;
    int   sel;
    bit   load;
    #2;
    dr_seen = disp_ready;
    m_dr = reset && !flush && (mq.size() < DEPTH);
    if (!reset || flush) begin
      mq.delete();
      m_iv  = 1'b0;
      m_out = '{default: '0};
    end else begin
      load = !m_iv || issue_ready;
      sel  = -1;
      foreach (mq[i]) begin
        if (sel < 0 && rdy_eff(mq[i].r1, mq[i].s1) && rdy_eff(mq[i].r2, mq[i].s2)) sel = i;
      end
      n.op = disp_opcode; n.s1 = disp_src1_tag; n.s2 = disp_src2_tag; n.d = disp_dest_tag;
      n.r1 = rdy_eff(disp_src1_ready, disp_src1_tag);
      n.r2 = rdy_eff(disp_src2_ready, disp_src2_tag);
      foreach (mq[i]) begin
        mq[i].r1 = rdy_eff(mq[i].r1, mq[i].s1);
        mq[i].r2 = rdy_eff(mq[i].r2, mq[i].s2);
      end
      if (load) begin
        if (sel >= 0) begin
          m_out = mq[sel];
          m_iv  = 1'b1;
          mq.delete(sel);
        end else begin
          m_iv  = 1'b0;
          m_out = '{default: '0};
        end
      end
      if (disp_valid && m_dr) mq.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_disp(input logic [4:0] op, input logic [5:0] s1, input logic r1,
                            input logic [5:0] s2, input logic r2, input logic [5:0] d);
    disp_valid = 1'b1; disp_opcode = op; disp_dest_tag = d;
    disp_src1_tag = s1; disp_src1_ready = r1;
    disp_src2_tag = s2; disp_src2_ready = r2;
    cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; issue_ready = 1'b1; idle();
    disp_opcode = '0; disp_src1_tag = '0; disp_src2_tag = '0; disp_dest_tag = '0;
    disp_src1_ready = 1'b0; disp_src2_ready = 1'b0; cdb_tag = '0;
    tick(); tick();
    tests_run++;
    if ({issue_valid, occupancy, issue_opcode, issue_src1_tag, issue_src2_tag, issue_dest_tag} !== 28'd0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%0b occ=%0d op=%0d got nonzero outputs", issue_valid, occupancy, issue_opcode);
    end
    tests_run++;
    if (dr_seen !== 1'b0) begin tests_failed++; $display("FAIL reset_disp_ready: got %0b want 0", dr_seen); end
    reset = 1'b1;
    #1;
    tests_run++;
    if (disp_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_disp_ready: got %0b want 1", disp_ready); end
  endtask

  task automatic test_in_order();
    issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive_disp(5'(i + 1), 6'd1, 1'b1, 6'd2, 1'b1, 6'(10 + i));
      else idle();
      tick();
      if (i >= 1 && i <= 3) begin
        tests_run++;
        if (issue_valid !== 1'b1 || issue_opcode !== 5'(i) || issue_dest_tag !== 6'(9 + i)) begin
          tests_failed++;
          $display("FAIL in_order_%0d: valid=%0b op=%0d dest=%0d want op=%0d dest=%0d", i, issue_valid, issue_opcode, issue_dest_tag, i, 9 + i);
        end
      end
    end
    tests_run++;
    if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
      tests_failed++; $display("FAIL in_order_drain: occ=%0d valid=%0b want 0 0", occupancy, issue_valid);
    end
  endtask

  task automatic test_wakeup();
    issue_ready = 1'b1;
    drive_disp(5'd10, 6'd6, 1'b0, 6'd3, 1'b1, 6'd20); tick();
    drive_disp(5'd11, 6'd1, 1'b1, 6'd2, 1'b1, 6'd21); tick();
    tests_run++;
    if (issue_valid !== 1'b0) begin tests_failed++; $display("FAIL wakeup_blocked: valid=%0b want 0", issue_valid); end
    idle(); tick();
    tests_run++;
    if (issue_valid !== 1'b1 || issue_opcode !== 5'd11) begin
      tests_failed++; $display("FAIL wakeup_b_first: valid=%0b op=%0d want 1 11", issue_valid, issue_opcode);
    end
    cdb_valid = 1'b1; cdb_tag = 6'd6; tick();
    tests_run++;
    if (issue_valid !== 1'b1 || issue_opcode !== 5'd10 || issue_src1_tag !== 6'd6 || occupancy !== 4'd0) begin
      tests_failed++; $display("FAIL wakeup_same_cycle: valid=%0b op=%0d s1=%0d occ=%0d want 1 10 6 0", issue_valid, issue_opcode, issue_src1_tag, occupancy);
    end
    idle(); tick();
  endtask

  task automatic test_bypass();
    issue_ready = 1'b1;
    drive_disp(5'd12, 6'd4, 1'b1, 6'd9, 1'b0, 6'd22);
    cdb_valid = 1'b1; cdb_tag = 6'd9;
    tick();
    tests_run++;
    if (occupancy !== 4'd1 || issue_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bypass_stored: occ=%0d valid=%0b want 1 0", occupancy, issue_valid);
    end
    idle(); tick();
    tests_run++;
    if (issue_valid !== 1'b1 || issue_opcode !== 5'd12 || issue_src2_tag !== 6'd9) begin
      tests_failed++; $display("FAIL bypass_issue: valid=%0b op=%0d s2=%0d want 1 12 9", issue_valid, issue_opcode, issue_src2_tag);
    end
    tick();
  endtask

  task automatic test_full();
    issue_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_disp(5'(i + 1), 6'd1, 1'b1, 6'd2, 1'b1, 6'(i)); tick();
    end
    tests_run++;
    if (occupancy !== 4'd8 || issue_valid !== 1'b1 || issue_opcode !== 5'd1) begin
      tests_failed++; $display("FAIL full_fill: occ=%0d valid=%0b op=%0d want 8 1 1", occupancy, issue_valid, issue_opcode);
    end
    drive_disp(5'd31, 6'd1, 1'b1, 6'd2, 1'b1, 6'd40); tick();
    tests_run++;
    if (dr_seen !== 1'b0 || occupancy !== 4'd8) begin
      tests_failed++; $display("FAIL full_reject: ready=%0b occ=%0d want 0 8", dr_seen, occupancy);
    end
    idle(); issue_ready = 1'b1; tick();
    tests_run++;
    if (dr_seen !== 1'b0 || issue_opcode !== 5'd2 || occupancy !== 4'd7) begin
      tests_failed++; $display("FAIL full_first_issue: ready=%0b op=%0d occ=%0d want 0 2 7", dr_seen, issue_opcode, occupancy);
    end
    tests_run++;
    if (disp_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_return: got %0b want 1", disp_ready); end
    for (int i = 3; i <= 9; i++) begin
      tick();
      tests_run++;
      if (issue_valid !== 1'b1 || issue_opcode !== 5'(i)) begin
        tests_failed++; $display("FAIL full_drain_%0d: valid=%0b op=%0d", i, issue_valid, issue_opcode);
      end
    end
    tick();
    tests_run++;
    if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
      tests_failed++; $display("FAIL full_empty: valid=%0b occ=%0d want 0 0", issue_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    issue_ready = 1'b0;
    drive_disp(5'd20, 6'd1, 1'b1, 6'd2, 1'b1, 6'd30); tick();
    drive_disp(5'd21, 6'd12, 1'b0, 6'd2, 1'b1, 6'd31); tick();
    idle(); cdb_valid = 1'b1; cdb_tag = 6'd12; tick();
    idle(); tick();
    tests_run++;
    if (issue_valid !== 1'b1 || issue_opcode !== 5'd20 || issue_dest_tag !== 6'd30 || occupancy !== 4'd1) begin
      tests_failed++; $display("FAIL bp_hold: valid=%0b op=%0d dest=%0d occ=%0d want 1 20 30 1", issue_valid, issue_opcode, issue_dest_tag, occupancy);
    end
    issue_ready = 1'b1; tick();
    tests_run++;
    if (issue_valid !== 1'b1 || issue_opcode !== 5'd21 || occupancy !== 4'd0) begin
      tests_failed++; $display("FAIL bp_release: valid=%0b op=%0d occ=%0d want 1 21 0", issue_valid, issue_opcode, occupancy);
    end
    tick();
  endtask

  task automatic test_flush(input bit use_reset);
    issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_disp(5'(i + 1), 6'd1, 1'b1, 6'd2, 1'b1, 6'(i + 1)); tick();
    end
    tests_run++;
    if (issue_valid !== 1'b1 || occupancy !== 4'd5) begin
      tests_failed++; $display("FAIL flush_setup_%0d: valid=%0b occ=%0d want 1 5", use_reset, issue_valid, occupancy);
    end
    drive_disp(5'd7, 6'd1, 1'b1, 6'd2, 1'b1, 6'd7);
    if (use_reset) reset = 1'b0; else flush = 1'b1;
    tick();
    tests_run++;
    if (dr_seen !== 1'b0 || {issue_valid, occupancy, issue_opcode, issue_src1_tag, issue_src2_tag, issue_dest_tag} !== 28'd0) begin
      tests_failed++; $display("FAIL flush_clear_%0d: ready=%0b valid=%0b occ=%0d op=%0d want all 0", use_reset, dr_seen, issue_valid, occupancy, issue_opcode);
    end
    reset = 1'b1;
    drive_disp(5'd8, 6'd1, 1'b1, 6'd2, 1'b1, 6'd8); tick();
    tests_run++;
    if (dr_seen !== 1'b1 || occupancy !== 4'd1) begin
      tests_failed++; $display("FAIL flush_accept_%0d: ready=%0b occ=%0d want 1 1", use_reset, dr_seen, occupancy);
    end
    idle(); issue_ready = 1'b1; tick(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      disp_valid      = ($urandom_range(0, 9) < 6);
      disp_opcode     = 5'($urandom_range(0, 31));
      disp_src1_tag   = 6'($urandom_range(0, 7));
      disp_src2_tag   = 6'($urandom_range(0, 7));
      disp_dest_tag   = 6'($urandom_range(0, 63));
      disp_src1_ready = ($urandom_range(0, 2) == 0);
      disp_src2_ready = ($urandom_range(0, 2) == 0);
      cdb_valid       = ($urandom_range(0, 1) == 1);
      cdb_tag         = 6'($urandom_range(0, 7));
      issue_ready     = ($urandom_range(0, 9) < 7);
      flush           = ($urandom_range(0, 59) == 0);
      reset           = ($urandom_range(0, 99) != 0);
      tick();
      tests_run++;
      if (dr_seen !== m_dr) begin
        tests_failed++; $display("FAIL rand_disp_ready@%0d: got %0b want %0b", n, dr_seen, m_dr);
      end
      tests_run++;
      if ({issue_valid, issue_opcode, issue_src1_tag, issue_src2_tag, issue_dest_tag, occupancy} !==
          {m_iv, m_out.op, m_out.s1, m_out.s2, m_out.d, 4'(mq.size())}) begin
        tests_failed++;
        $display("FAIL rand_outputs@%0d: got v=%0b op=%0d s1=%0d s2=%0d d=%0d occ=%0d want v=%0b op=%0d s1=%0d s2=%0d d=%0d occ=%0d",
                 n, issue_valid, issue_opcode, issue_src1_tag, issue_src2_tag, issue_dest_tag, occupancy,
                 m_iv, m_out.op, m_out.s1, m_out.s2, m_out.d, mq.size());
      end
    end
    reset = 1'b1; idle();
  endtask

  initial begin
    m_iv = 1'b0;
    m_out = '{default: '0};
    test_reset();
    test_in_order();
    test_wakeup();
    test_bypass();
    test_full();
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
